// File: rtl/loongarch_pkg.sv
// Shared constants for the LoongArch pipeline: datapath widths, one-hot ALU opcode
// bit positions and the widths of the inter-stage payloads.
package loongarch_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ALU_OP_W = 12;

  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_NOR  = 5;
  localparam int ALU_OP_OR   = 6;
  localparam int ALU_OP_XOR  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRL  = 9;
  localparam int ALU_OP_SRA  = 10;
  localparam int ALU_OP_LUI  = 11;

  // ID->EX: alu_op, src1_is_pc, src2_is_imm, pc, rj, rkd, imm, dest, gr_we, mem_we, res_from_mem
  localparam int DS_TO_ES_W = ALU_OP_W + 2 + 4 * DATA_W + REG_AW + 3;
  // EX->MEM: pc, alu_result, store_data, dest, gr_we, mem_we, res_from_mem
  localparam int ES_TO_MS_W = 3 * DATA_W + REG_AW + 3;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with a one-hot opcode; zero or multi-hot opcodes yield 0.
module exe_stage_alu
  import loongarch_pkg::*;
#(
  parameter int DATA_W   = loongarch_pkg::DATA_W,
  parameter int ALU_OP_W = loongarch_pkg::ALU_OP_W
) (
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_src1,
  input  logic [DATA_W-1:0]   alu_src2,
  output logic [DATA_W-1:0]   alu_result,
  output logic                zero
);

  logic [4:0] shamt;

  assign shamt = alu_src2[4:0];

  always_comb begin
    alu_result = '0;
    if ($onehot(alu_op)) begin
      case (1'b1)
        alu_op[ALU_OP_ADD]:  alu_result = alu_src1 + alu_src2;
        alu_op[ALU_OP_SUB]:  alu_result = alu_src1 - alu_src2;
        alu_op[ALU_OP_SLT]:  alu_result = DATA_W'($signed(alu_src1) < $signed(alu_src2));
        alu_op[ALU_OP_SLTU]: alu_result = DATA_W'(alu_src1 < alu_src2);
        alu_op[ALU_OP_AND]:  alu_result = alu_src1 & alu_src2;
        alu_op[ALU_OP_NOR]:  alu_result = ~(alu_src1 | alu_src2);
        alu_op[ALU_OP_OR]:   alu_result = alu_src1 | alu_src2;
        alu_op[ALU_OP_XOR]:  alu_result = alu_src1 ^ alu_src2;
        alu_op[ALU_OP_SLL]:  alu_result = alu_src1 << shamt;
        alu_op[ALU_OP_SRL]:  alu_result = alu_src1 >> shamt;
        alu_op[ALU_OP_SRA]:  alu_result = $unsigned($signed(alu_src1) >>> shamt);
        // ID has already placed the upper immediate in position
        alu_op[ALU_OP_LUI]:  alu_result = alu_src2;
        default:             alu_result = '0;
      endcase
    end
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: registers the ID payload, forms ALU operands, hands results to MEM
// and exports bypass / load-use information back to ID.
module exe_stage
  import loongarch_pkg::*;
#(
  parameter int DATA_W   = loongarch_pkg::DATA_W,
  parameter int ALU_OP_W = loongarch_pkg::ALU_OP_W,
  parameter int REG_AW   = loongarch_pkg::REG_AW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [ALU_OP_W-1:0] ds_alu_op,
  input  logic                ds_src1_is_pc,
  input  logic                ds_src2_is_imm,
  input  logic [DATA_W-1:0]   ds_pc,
  input  logic [DATA_W-1:0]   ds_rj_value,
  input  logic [DATA_W-1:0]   ds_rkd_value,
  input  logic [DATA_W-1:0]   ds_imm,
  input  logic [REG_AW-1:0]   ds_dest,
  input  logic                ds_gr_we,
  input  logic                ds_mem_we,
  input  logic                ds_res_from_mem,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic [DATA_W-1:0]   es_pc,
  output logic [DATA_W-1:0]   es_alu_result,
  output logic [DATA_W-1:0]   es_store_data,
  output logic [REG_AW-1:0]   es_dest,
  output logic                es_gr_we,
  output logic                es_mem_we,
  output logic                es_res_from_mem,
  output logic                es_fwd_valid,
  output logic [DATA_W-1:0]   es_fwd_data,
  output logic                es_load_hazard
);

  logic                es_valid;
  logic                es_ready_go;
  logic                es_load;
  logic [ALU_OP_W-1:0] es_alu_op;
  logic                es_src1_is_pc;
  logic                es_src2_is_imm;
  logic [DATA_W-1:0]   es_rj_value;
  logic [DATA_W-1:0]   es_imm;
  logic                es_store_en;
  logic [DATA_W-1:0]   alu_src1;
  logic [DATA_W-1:0]   alu_src2;

  // Handshake: a transfer happens on a rising edge where the producer's valid and the
  // consumer's allowin are both high. EX accepts when empty or when its instruction
  // leaves this cycle; flush kills the held instruction and blocks any new one.
  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go && !flush;
  assign es_load        = ds_to_es_valid && es_allowin && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (flush) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_alu_op       <= '0;
      es_src1_is_pc   <= 1'b0;
      es_src2_is_imm  <= 1'b0;
      es_pc           <= '0;
      es_rj_value     <= '0;
      es_store_data   <= '0;
      es_imm          <= '0;
      es_dest         <= '0;
      es_gr_we        <= 1'b0;
      es_store_en     <= 1'b0;
      es_res_from_mem <= 1'b0;
    end else if (es_load) begin
      es_alu_op       <= ds_alu_op;
      es_src1_is_pc   <= ds_src1_is_pc;
      es_src2_is_imm  <= ds_src2_is_imm;
      es_pc           <= ds_pc;
      es_rj_value     <= ds_rj_value;
      es_store_data   <= ds_rkd_value;
      es_imm          <= ds_imm;
      es_dest         <= ds_dest;
      es_gr_we        <= ds_gr_we;
      es_store_en     <= ds_mem_we;
      es_res_from_mem <= ds_res_from_mem;
    end
  end

  assign alu_src1 = es_src1_is_pc  ? es_pc  : es_rj_value;
  assign alu_src2 = es_src2_is_imm ? es_imm : es_store_data;

  exe_stage_alu #(
    .DATA_W   (DATA_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu (
    .alu_op     (es_alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (es_alu_result),
    .zero       ()
  );

  // Stale payload must never look like a live store or bypass source
  assign es_mem_we      = es_valid && es_store_en;
  assign es_fwd_valid   = es_valid && es_gr_we && (es_dest != '0);
  assign es_fwd_data    = es_alu_result;
  assign es_load_hazard = es_fwd_valid && es_res_from_mem;

endmodule
